// File: rtl/sample_acc_ctrl.sv
// Controller that sums 8 unsigned samples, using an external 3-bit sample counter.
// Overflow handling is set by SAMPLE_ACC_SAT_EN: defined clamps at 1023, undefined wraps mod 1024.
module sample_acc_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       cnt_co,
  output logic       in_ready,
  output logic       cnt_en,
  output logic       cnt_clean,
  output logic       busy,
  output logic       done,
  output logic [9:0] sum
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    ACCUM = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [9:0]  acc_q, acc_d;
  logic [10:0] acc_ext;
  logic [9:0]  acc_add;
  logic        accept;

  // A full-width sum keeps the carry visible, so the clamp decision is a single bit.
  assign acc_ext = {1'b0, acc_q} + {3'b000, in_data};

`ifdef SAMPLE_ACC_SAT_EN
  assign acc_add = acc_ext[10] ? 10'd1023 : acc_ext[9:0];
`else
  assign acc_add = acc_ext[9:0];
`endif

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    in_ready  = 1'b0;
    cnt_clean = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    accept    = 1'b0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) state_d = CLEAR;
      end
      CLEAR: begin
        cnt_clean = 1'b1;
        acc_d     = 10'd0;
        state_d   = ACCUM;
      end
      ACCUM: begin
        in_ready = 1'b1;
        accept   = in_valid;
        if (accept) begin
          acc_d = acc_add;
          if (cnt_co) state_d = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Strobes are forced low while reset is asserted, whatever state the register still holds.
    if (!rst) begin
      in_ready  = 1'b0;
      cnt_clean = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      accept    = 1'b0;
    end
  end

  assign cnt_en = accept;
  assign sum    = acc_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      acc_q   <= 10'd0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
    end
  end

endmodule
